// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//
// Steps through an external note ROM (one byte per note: [7:4] tone,
// [3:0] duration in beats) and drives the tone index for the tone
// decoder.
//
// A duration of 0 is the end marker. Tones 12..15 are rests: they are
// timed like notes, but sound_en stays low.
//
// Optional build macro:
//   NOTE_GAP_EN - inserts a silent GAP state of GAP_CLKS cycles after
//                 every completed note, except the one that ends the ROM.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        begins playback when sampled in IDLE (ignored if stop is high)
//   stop         aborts playback from any busy state and returns to IDLE
//   note_addr    ROM address
//   note_data    ROM word, read combinationally from note_addr
//   tone         latched tone index (0..11 = do..si)
//   sound_en     high while a tonal note is playing
//   busy         high in every state except IDLE
//   done         one-cycle pulse on normal completion
//   dbg_state_o  current FSM state encoding
//                (IDLE=0, FETCH=1, PLAY=2, GAP=3, DONE=4)
// ---------------------------------------------------------------------------
module melody_sequencer #(
    parameter int CLKS_PER_BEAT = 12500000,
    parameter int ADDR_W        = 5,
    parameter int GAP_CLKS      = 1250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [7:0]        note_data,
    output logic [3:0]        tone,
    output logic              sound_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state_o
);

    if (CLKS_PER_BEAT < 2) begin : g_bad_beat
        $error("CLKS_PER_BEAT must be at least 2");
    end
    if (GAP_CLKS < 1) begin : g_bad_gap
        $error("GAP_CLKS must be at least 1");
    end

    localparam int BEAT_W = $clog2(CLKS_PER_BEAT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CLKS_PER_BEAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
`ifdef NOTE_GAP_EN
        S_GAP   = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          tone_q, tone_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          left_q, left_d;

`ifdef NOTE_GAP_EN
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
    logic [GAP_W-1:0]    gap_q, gap_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tone_d  = tone_q;
        beat_d  = beat_q;
        left_d  = left_q;
`ifdef NOTE_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (note_data[3:0] == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    tone_d  = note_data[7:4];
                    left_d  = note_data[3:0];
                    beat_d  = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d = '0;
                    if (left_q == 4'd1) begin
                        // The last ROM entry ends the melody; the address
                        // must not wrap back to the first note.
                        if (addr_q == {ADDR_W{1'b1}}) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
`ifdef NOTE_GAP_EN
                            gap_d   = '0;
                            state_d = S_GAP;
`else
                            state_d = S_FETCH;
`endif
                        end
                    end else begin
                        left_d = left_q - 4'd1;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
`ifdef NOTE_GAP_EN
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // stop overrides the normal flow; the done pulse of a DONE cycle is
        // already visible, so only the next state is affected.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
        // Every return to IDLE rewinds the melody to its first note.
        if (state_d == S_IDLE) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            tone_q  <= '0;
            beat_q  <= '0;
            left_q  <= '0;
`ifdef NOTE_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tone_q  <= tone_d;
            beat_q  <= beat_d;
            left_q  <= left_d;
`ifdef NOTE_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign note_addr   = addr_q;
    assign tone        = tone_q;
    assign sound_en    = (state_q == S_PLAY) && (tone_q < 4'd12);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer. Two instances share the clock and
// reset: dut_a (ADDR_W=5) for the main scenarios and dut_b (ADDR_W=2) for
// the implicit end of the ROM. Each cycle's expected trace word
// {state, addr, tone, sound_en, busy, done} is queued before stimulus is
// applied and popped at the following negedge.
module tb_melody_sequencer;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_PLAY  = 2;
    localparam int S_GAP   = 3;
    localparam int S_DONE  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start_a = 1'b0, stop_a = 1'b0;
    logic       start_b = 1'b0, stop_b = 1'b0;
    logic [4:0] addr_a;
    logic [1:0] addr_b;
    logic [7:0] data_a, data_b;
    logic [3:0] tone_a, tone_b;
    logic       snd_a, busy_a, done_a;
    logic       snd_b, busy_b, done_b;
    logic [2:0] st_a, st_b;

    logic [7:0] rom_a [32];
    logic [7:0] rom_b [4];
    assign data_a = rom_a[addr_a];
    assign data_b = rom_b[addr_b];

    melody_sequencer #(.CLKS_PER_BEAT(4), .ADDR_W(5), .GAP_CLKS(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop_a),
        .note_addr(addr_a), .note_data(data_a), .tone(tone_a),
        .sound_en(snd_a), .busy(busy_a), .done(done_a), .dbg_state_o(st_a)
    );

    melody_sequencer #(.CLKS_PER_BEAT(4), .ADDR_W(2), .GAP_CLKS(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b),
        .note_addr(addr_b), .note_data(data_b), .tone(tone_b),
        .sound_en(snd_b), .busy(busy_b), .done(done_b), .dbg_state_o(st_b)
    );

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          sel_b = 1'b0;
    logic [14:0] exp_q [$];

    function automatic logic [14:0] tw(input int s, input int a, input int t,
                                       input int sn, input int b, input int d);
        return {3'(s), 5'(a), 4'(t), 1'(sn), 1'(b), 1'(d)};
    endfunction

    function automatic logic [14:0] trace();
        if (sel_b) return {st_b, 3'b000, addr_b, tone_b, snd_b, busy_b, done_b};
        return {st_a, addr_a, tone_a, snd_a, busy_a, done_a};
    endfunction

    task automatic check_eq(input string tag, input logic [14:0] act, input logic [14:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got st=%0d addr=%0d tone=%h snd=%b busy=%b done=%b, want st=%0d addr=%0d tone=%h snd=%b busy=%b done=%b",
                     tag, cyc, act[14:12], act[11:7], act[6:3], act[2], act[1], act[0],
                     exp[14:12], exp[11:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic expect_n(input int n, input logic [14:0] w);
        repeat (n) exp_q.push_back(w);
    endtask

    task automatic tick(input logic st, input logic sp, input logic rs, input string tag);
        reset   = rs;
        start_a = sel_b ? 1'b0 : st;
        stop_a  = sel_b ? 1'b0 : sp;
        start_b = sel_b ? st : 1'b0;
        stop_b  = sel_b ? sp : 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s cycle %0d: no expected entry queued", tag, cyc);
        end else begin
            check_eq(tag, trace(), exp_q.pop_front());
        end
    endtask

    task automatic run(input int n, input logic st, input logic sp, input logic rs, input string tag);
        repeat (n) tick(st, sp, rs, tag);
    endtask

    task automatic do_reset();
        expect_n(2, tw(S_IDLE, 0, 0, 0, 0, 0));
        run(2, 1'b0, 1'b0, 1'b1, "reset_values");
        cyc = 0;
    endtask

    task automatic load_rom_a(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        for (int i = 0; i < 32; i++) rom_a[i] = 8'h00;
        rom_a[0] = w0;
        rom_a[1] = w1;
        rom_a[2] = w2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rom_b[0] = 8'h01; rom_b[1] = 8'h11; rom_b[2] = 8'h21; rom_b[3] = 8'h31;
        load_rom_a(8'h92, 8'hF1, 8'h00);

        // start and stop together in IDLE: nothing happens
        sel_b = 1'b0;
        do_reset();
        expect_n(1, tw(S_IDLE, 0, 0, 0, 0, 0));
        run(1, 1'b1, 1'b1, 1'b0, "start_stop_idle");

        // stop mid-note at cycle 5
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  0, 9, 1, 1, 0));
        expect_n(2, tw(S_IDLE,  0, 9, 0, 0, 0));
        run(1, 1'b1, 1'b0, 1'b0, "stop");
        run(4, 1'b0, 1'b0, 1'b0, "stop");
        run(1, 1'b0, 1'b1, 1'b0, "stop");
        run(1, 1'b0, 1'b0, 1'b0, "stop");

        // reset at cycle 7, restart at cycle 10
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0, 0, 1, 0));
        expect_n(6, tw(S_PLAY,  0, 9, 1, 1, 0));
        expect_n(3, tw(S_IDLE,  0, 0, 0, 0, 0));
        expect_n(1, tw(S_FETCH, 0, 0, 0, 1, 0));
        expect_n(2, tw(S_PLAY,  0, 9, 1, 1, 0));
        run(1, 1'b1, 1'b0, 1'b0, "mid_reset");
        run(6, 1'b0, 1'b0, 1'b0, "mid_reset");
        run(1, 1'b0, 1'b0, 1'b1, "mid_reset");
        run(2, 1'b0, 1'b0, 1'b0, "mid_reset");
        run(1, 1'b1, 1'b0, 1'b0, "mid_reset");
        run(2, 1'b0, 1'b0, 1'b0, "mid_reset");

`ifdef NOTE_GAP_EN
        // gap between two repeated tones
        load_rom_a(8'h51, 8'h51, 8'h00);
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  0, 5, 1, 1, 0));
        expect_n(3, tw(S_GAP,   1, 5, 0, 1, 0));
        expect_n(1, tw(S_FETCH, 1, 5, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  1, 5, 1, 1, 0));
        expect_n(3, tw(S_GAP,   2, 5, 0, 1, 0));
        expect_n(1, tw(S_FETCH, 2, 5, 0, 1, 0));
        expect_n(1, tw(S_DONE,  2, 5, 0, 1, 1));
        expect_n(1, tw(S_IDLE,  0, 5, 0, 0, 0));
        run(1, 1'b1, 1'b0, 1'b0, "gap_play");
        run(18, 1'b0, 1'b0, 1'b0, "gap_play");

        // stop during the gap
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  0, 5, 1, 1, 0));
        expect_n(1, tw(S_GAP,   1, 5, 0, 1, 0));
        expect_n(2, tw(S_IDLE,  0, 5, 0, 0, 0));
        run(1, 1'b1, 1'b0, 1'b0, "gap_stop");
        run(5, 1'b0, 1'b0, 1'b0, "gap_stop");
        run(1, 1'b0, 1'b1, 1'b0, "gap_stop");
        run(1, 1'b0, 1'b0, 1'b0, "gap_stop");
`else
        // basic playback
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0,  0, 1, 0));
        expect_n(8, tw(S_PLAY,  0, 9,  1, 1, 0));
        expect_n(1, tw(S_FETCH, 1, 9,  0, 1, 0));
        expect_n(4, tw(S_PLAY,  1, 15, 0, 1, 0));
        expect_n(1, tw(S_FETCH, 2, 15, 0, 1, 0));
        expect_n(1, tw(S_DONE,  2, 15, 0, 1, 1));
        expect_n(1, tw(S_IDLE,  0, 15, 0, 0, 0));
        run(1, 1'b1, 1'b0, 1'b0, "basic");
        run(16, 1'b0, 1'b0, 1'b0, "basic");

        // start held high cycles 0..20
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0,  0, 1, 0));
        expect_n(8, tw(S_PLAY,  0, 9,  1, 1, 0));
        expect_n(1, tw(S_FETCH, 1, 9,  0, 1, 0));
        expect_n(4, tw(S_PLAY,  1, 15, 0, 1, 0));
        expect_n(1, tw(S_FETCH, 2, 15, 0, 1, 0));
        expect_n(1, tw(S_DONE,  2, 15, 0, 1, 1));
        expect_n(1, tw(S_IDLE,  0, 15, 0, 0, 0));
        expect_n(1, tw(S_FETCH, 0, 15, 0, 1, 0));
        expect_n(3, tw(S_PLAY,  0, 9,  1, 1, 0));
        run(21, 1'b1, 1'b0, 1'b0, "start_busy");

        // implicit end on the last address of a 4-entry ROM
        sel_b = 1'b1;
        do_reset();
        expect_n(1, tw(S_FETCH, 0, 0, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  0, 0, 1, 1, 0));
        expect_n(1, tw(S_FETCH, 1, 0, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  1, 1, 1, 1, 0));
        expect_n(1, tw(S_FETCH, 2, 1, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  2, 2, 1, 1, 0));
        expect_n(1, tw(S_FETCH, 3, 2, 0, 1, 0));
        expect_n(4, tw(S_PLAY,  3, 3, 1, 1, 0));
        expect_n(1, tw(S_DONE,  3, 3, 0, 1, 1));
        expect_n(1, tw(S_IDLE,  0, 3, 0, 0, 0));
        run(1, 1'b1, 1'b0, 1'b0, "implicit_end");
        run(21, 1'b0, 1'b0, 1'b0, "implicit_end");
        sel_b = 1'b0;
`endif

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
